decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal: 32, 64).
REQ-002 SHALL have parameter DEPTH, default 4, decoded-entry queue depth (power of 2, >= 2).
REQ-003 SHALL have ports: clk  in  1  clock; rst_n  in  1  synchronous active-low reset.
REQ-004 SHALL have ports: in_valid in 1 instr offered; in_ready out 1 queue can accept; in_instr in 32 instruction word; in_pc in XLEN instruction address.
REQ-005 SHALL have port: flush  in  1  discard all queued entries.
REQ-006 SHALL have ports: out_valid out 1 entry available; out_ready in 1 consumer accepts.
REQ-007 SHALL have ports: out_opcode out 7; out_func3 out 3; out_func7 out 7; out_rd out 5; out_rs1 out 5; out_rs2 out 5; out_imm out XLEN; out_fmt out 3; out_pc out XLEN; out_illegal out 1.

Function
REQ-008 SHALL push decoded entry when in_valid && in_ready; SHALL pop head when out_valid && out_ready.
REQ-009 SHALL drive in_ready = (count < DEPTH), independent of same-cycle pop (no pass-through when full).
REQ-010 SHALL drive out_valid = (count > 0); out_* fields SHALL reflect head entry, registered, no combinational bypass from inputs.
REQ-011 Latency: instr pushed in cycle N into empty queue SHALL appear with out_valid=1 in cycle N+1.
REQ-012 Simultaneous push and pop at 0<count<DEPTH SHALL leave count unchanged, FIFO order preserved.
REQ-013 Read/write pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-014 flush SHALL set count and pointers to 0 next cycle; flush has priority over same-cycle push and pop.
REQ-015 Field extract: opcode=[6:0], rd=[11:7], func3=[14:12], rs1=[19:15], rs2=[24:20], func7=[31:25].
REQ-016 fmt encoding: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 none.
REQ-017 R (0110011, 1110011 treated I): imm=0, fmt=0.
REQ-018 I (0010011, 1100111, 0000011, 1110011, 0001111): imm = sign-ext instr[31:20] to XLEN; exception: opcode 0010011 with func3 001/101 SHALL use zero-ext instr[31:20].
REQ-019 S (0100011): imm = sign-ext {instr[31:25], instr[11:7]}.
REQ-020 B (1100011): imm = sign-ext {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
REQ-021 U (0110111, 0010111): imm = sign-ext {instr[31:12], 12'b0} to XLEN.
REQ-022 J (1101111): imm = sign-ext {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-023 Any other opcode: imm=0, fmt=7.
REQ-024 out_pc SHALL equal in_pc of the same entry.

Reset
REQ-025 rst_n low at posedge clk SHALL clear count and pointers; out_valid=0, in_ready=1 next cycle.
REQ-026 After reset, out_* data fields SHALL read 0 (storage array cleared); in-flight entries SHALL be discarded.
REQ-027 Reset SHALL take priority over flush, push and pop.

Configuration
REQ-028 Macro DECODE_ILLEGAL_CHK_EN defined: out_illegal=1 for entry whose instr[1:0]!=2'b11 or fmt=7.
REQ-029 Macro undefined: out_illegal port present, tied 0; no check logic synthesised.

Verification
REQ-030 Push 0xFFF00093 into empty queue, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, fmt=1, imm=0xFFFFFFFF.
REQ-031 Push 0x4010D093 (srai) -> imm=0x00000401, func3=5, fmt=1; push 0xFE000EE3 -> imm=0xFFFFFFFC, fmt=3; push 0xFF9FF06F -> imm=0xFFFFFFF8, fmt=5.
REQ-032 XLEN=64, push 0x123452B7 -> imm=0x0000000012345000, rd=5, fmt=4.
REQ-033 DEPTH=4, out_ready=0, offer 5 instrs -> in_ready=0 after 4th push, 5th held; one pop -> in_ready=1 next cycle, order 1..5 preserved.
REQ-034 Queue at 3 entries, flush and in_valid same cycle -> next cycle out_valid=0, count=0; rst_n low mid-burst -> same result.
REQ-035 With DECODE_ILLEGAL_CHK_EN, push 0x00000000 -> out_illegal=1, fmt=7; without macro -> out_illegal=0.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: decodes RV32/RV64 instruction words at enqueue time and holds
// the decoded entries in a DEPTH-deep FIFO. The head entry drives the out_*
// fields directly from registered storage, so there is no path from in_* to out_*.
//
// Parameters: XLEN (32 or 64) datapath width, DEPTH (power of 2, >= 2).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     enqueue handshake; in_instr (32b), in_pc (XLEN)
//   flush                 drop every queued entry
//   out_valid/out_ready   dequeue handshake
//   out_opcode/func3/func7/rd/rs1/rs2   raw fields of the head instruction
//   out_imm (XLEN), out_fmt (0 R,1 I,2 S,3 B,4 U,5 J,7 none), out_pc, out_illegal
// Build option: define DECODE_ILLEGAL_CHK_EN to flag entries whose instr[1:0]
// is not 2'b11 or whose opcode is unknown; otherwise out_illegal is tied 0.
module decode_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  localparam logic [2:0] FmtR    = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;
  localparam logic [2:0] FmtNone = 3'd7;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] imm_q   [DEPTH];
  logic [2:0]      fmt_q   [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];

  logic push, pop;
  assign in_ready  = (count_q < DepthCnt);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Decode of the incoming word; immediates are built at 32 bits and then
  // sign-extended, which also covers the zero-extended shift-amount case.
  logic [31:0]     imm32;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    imm32   = '0;
    dec_fmt = FmtNone;
    case (in_instr[6:0])
      7'b0110011: dec_fmt = FmtR;
      7'b0010011: begin
        dec_fmt = FmtI;
        // Immediate shifts carry func7 in the upper bits; keep them unsigned.
        if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) begin
          imm32 = {20'b0, in_instr[31:20]};
        end else begin
          imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b1100111, 7'b0000011, 7'b1110011, 7'b0001111: begin
        dec_fmt = FmtI;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt = FmtS;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FmtB;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FmtU;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FmtJ;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      default: begin
        dec_fmt = FmtNone;
        imm32   = '0;
      end
    endcase
    dec_imm        = {XLEN{imm32[31]}};
    dec_imm[31:0]  = imm32;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        imm_q[i]   <= '0;
        fmt_q[i]   <= '0;
        pc_q[i]    <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        instr_q[wr_ptr_q] <= in_instr;
        imm_q[wr_ptr_q]   <= dec_imm;
        fmt_q[wr_ptr_q]   <= dec_fmt;
        pc_q[wr_ptr_q]    <= in_pc;
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_opcode = instr_q[rd_ptr_q][6:0];
  assign out_rd     = instr_q[rd_ptr_q][11:7];
  assign out_func3  = instr_q[rd_ptr_q][14:12];
  assign out_rs1    = instr_q[rd_ptr_q][19:15];
  assign out_rs2    = instr_q[rd_ptr_q][24:20];
  assign out_func7  = instr_q[rd_ptr_q][31:25];
  assign out_imm    = imm_q[rd_ptr_q];
  assign out_fmt    = fmt_q[rd_ptr_q];
  assign out_pc     = pc_q[rd_ptr_q];

`ifdef DECODE_ILLEGAL_CHK_EN
  logic ill_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ill_q[i] <= 1'b0;
      end
    end else if (!flush && push) begin
      ill_q[wr_ptr_q] <= (in_instr[1:0] != 2'b11) || (dec_fmt == FmtNone);
    end
  end

  assign out_illegal = ill_q[rd_ptr_q];
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [6:0]  out_opcode, out_func7;
  logic [2:0]  out_func3, out_fmt;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_illegal;

  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [31:0] in_instr64;
  logic [63:0] in_pc64, out_imm64, out_pc64;
  logic [6:0]  out_opcode64, out_func7_64;
  logic [2:0]  out_func3_64, out_fmt64;
  logic [4:0]  out_rd64, out_rs1_64, out_rs2_64;
  logic        out_illegal64;

  int total = 0;
  int bad   = 0;

`ifdef DECODE_ILLEGAL_CHK_EN
  localparam bit IllEn = 1'b1;
`else
  localparam bit IllEn = 1'b0;
`endif

  always #5 clk = ~clk;

  decode_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  decode_queue #(.XLEN(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
    .flush(1'b0), .out_valid(out_valid64), .out_ready(out_ready64),
    .out_opcode(out_opcode64), .out_func3(out_func3_64), .out_func7(out_func7_64),
    .out_rd(out_rd64), .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_pc(out_pc64), .out_illegal(out_illegal64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // addi x1, x0, k
  function automatic logic [31:0] mk(input int k);
    logic [11:0] k12;
    k12 = 12'(k);
    return {k12, 20'h00093};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    in_valid64 = 1'b0; out_ready64 = 1'b0; in_instr64 = '0; in_pc64 = '0;
    step(); step();
    rst_n = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_imm !== 32'h0) begin bad++; $display("FAIL reset_imm got=%h exp=0", out_imm); end
    total++; if (out_fmt !== 3'd0) begin bad++; $display("FAIL reset_fmt got=%0d exp=0", out_fmt); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    total++; if (out_valid64 !== 1'b0) begin bad++; $display("FAIL reset_out_valid64 got=%b exp=0", out_valid64); end
  endtask

  task automatic test_decode();
    logic [31:0] t_instr [7] = '{32'hFFF00093, 32'h4010D093, 32'hFE000EE3, 32'hFF9FF06F,
                                 32'h00112623, 32'h002081B3, 32'h00000000};
    logic [31:0] t_imm   [7] = '{32'hFFFFFFFF, 32'h00000401, 32'hFFFFFFFC, 32'hFFFFFFF8,
                                 32'h0000000C, 32'h00000000, 32'h00000000};
    logic [2:0]  t_fmt   [7] = '{3'd1, 3'd1, 3'd3, 3'd5, 3'd2, 3'd0, 3'd7};
    logic [4:0]  t_rd    [7] = '{5'd1, 5'd1, 5'd29, 5'd0, 5'd12, 5'd3, 5'd0};
    logic [2:0]  t_f3    [7] = '{3'd0, 3'd5, 3'd0, 3'd7, 3'd2, 3'd0, 3'd0};
    logic [4:0]  t_rs1   [7] = '{5'd0, 5'd1, 5'd0, 5'd31, 5'd2, 5'd1, 5'd0};
    logic [4:0]  t_rs2   [7] = '{5'd31, 5'd1, 5'd0, 5'd25, 5'd1, 5'd2, 5'd0};
    logic [6:0]  t_f7    [7] = '{7'h7F, 7'h20, 7'h7F, 7'h7F, 7'h00, 7'h00, 7'h00};
    logic [31:0] pc;
    logic        ill;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pc = 32'h1000 + 32'(i * 4);
      ill = IllEn && (i == 6);
      in_valid = 1'b1; in_instr = t_instr[i]; in_pc = pc;
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dec%0d_valid got=%b exp=1", i, out_valid); end
      total++; if (out_imm !== t_imm[i]) begin bad++; $display("FAIL dec%0d_imm got=%h exp=%h", i, out_imm, t_imm[i]); end
      total++; if (out_fmt !== t_fmt[i]) begin bad++; $display("FAIL dec%0d_fmt got=%0d exp=%0d", i, out_fmt, t_fmt[i]); end
      total++; if (out_rd !== t_rd[i]) begin bad++; $display("FAIL dec%0d_rd got=%0d exp=%0d", i, out_rd, t_rd[i]); end
      total++; if (out_func3 !== t_f3[i]) begin bad++; $display("FAIL dec%0d_func3 got=%0d exp=%0d", i, out_func3, t_f3[i]); end
      total++; if (out_rs1 !== t_rs1[i]) begin bad++; $display("FAIL dec%0d_rs1 got=%0d exp=%0d", i, out_rs1, t_rs1[i]); end
      total++; if (out_rs2 !== t_rs2[i]) begin bad++; $display("FAIL dec%0d_rs2 got=%0d exp=%0d", i, out_rs2, t_rs2[i]); end
      total++; if (out_func7 !== t_f7[i]) begin bad++; $display("FAIL dec%0d_func7 got=%h exp=%h", i, out_func7, t_f7[i]); end
      total++; if (out_opcode !== t_instr[i][6:0]) begin bad++; $display("FAIL dec%0d_opcode got=%h exp=%h", i, out_opcode, t_instr[i][6:0]); end
      total++; if (out_pc !== pc) begin bad++; $display("FAIL dec%0d_pc got=%h exp=%h", i, out_pc, pc); end
      total++; if (out_illegal !== ill) begin bad++; $display("FAIL dec%0d_illegal got=%b exp=%b", i, out_illegal, ill); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dec_drained got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_xlen64();
    in_valid64 = 1'b1; in_instr64 = 32'h123452B7; in_pc64 = 64'h8000_0000_0000_0010;
    step();
    in_valid64 = 1'b0;
    total++; if (out_valid64 !== 1'b1) begin bad++; $display("FAIL x64_valid got=%b exp=1", out_valid64); end
    total++; if (out_imm64 !== 64'h0000_0000_1234_5000) begin bad++; $display("FAIL x64_imm got=%h exp=0000000012345000", out_imm64); end
    total++; if (out_rd64 !== 5'd5) begin bad++; $display("FAIL x64_rd got=%0d exp=5", out_rd64); end
    total++; if (out_fmt64 !== 3'd4) begin bad++; $display("FAIL x64_fmt got=%0d exp=4", out_fmt64); end
    total++; if (out_pc64 !== 64'h8000_0000_0000_0010) begin bad++; $display("FAIL x64_pc got=%h exp=8000000000000010", out_pc64); end
    in_valid64 = 1'b1; in_instr64 = 32'h80000537; in_pc64 = 64'h14;  // lui x10, 0x80000
    step();
    in_valid64 = 1'b0; out_ready64 = 1'b1;
    step();
    total++; if (out_imm64 !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL x64_imm_neg got=%h exp=ffffffff80000000", out_imm64); end
    step();
    out_ready64 = 1'b0;
    total++; if (out_valid64 !== 1'b0) begin bad++; $display("FAIL x64_drained got=%b exp=0", out_valid64); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_ready_before%0d got=%b exp=1", k, in_ready); end
      in_valid = 1'b1; in_instr = mk(k); in_pc = 32'(k * 4);
      step();
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready_after4 got=%b exp=0", in_ready); end
    total++; if (out_imm !== 32'd1) begin bad++; $display("FAIL full_head1 got=%0d exp=1", out_imm); end
    in_instr = mk(5); in_pc = 32'd20;
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_fifth_held got=%b exp=0", in_ready); end
    total++; if (out_imm !== 32'd1) begin bad++; $display("FAIL full_head_still1 got=%0d exp=1", out_imm); end
    out_ready = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop got=%b exp=1", in_ready); end
    total++; if (out_imm !== 32'd2) begin bad++; $display("FAIL full_head2 got=%0d exp=2", out_imm); end
    step();
    in_valid = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      total++; if (out_imm !== 32'(k)) begin bad++; $display("FAIL full_order%0d got=%0d exp=%0d", k, out_imm, k); end
      total++; if (out_pc !== 32'(k * 4)) begin bad++; $display("FAIL full_pc%0d got=%0d exp=%0d", k, out_pc, k * 4); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_drained got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 6; k <= 8; k++) begin
      in_valid = 1'b1; in_instr = mk(k); in_pc = 32'(k * 4);
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d got=%b exp=1", k, out_valid); end
      total++; if (out_imm !== 32'(k)) begin bad++; $display("FAIL b2b_head%0d got=%0d exp=%0d", k, out_imm, k); end
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_instr = mk(k); in_pc = 32'(k * 4);
      step();
    end
    flush = 1'b1; in_instr = mk(9);
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    in_valid = 1'b1; in_instr = mk(10); in_pc = 32'd40;
    step();
    in_valid = 1'b0;
    total++; if (out_imm !== 32'd10) begin bad++; $display("FAIL flush_refill got=%0d exp=10", out_imm); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_single got=%b exp=0", out_valid); end
    for (int k = 11; k <= 12; k++) begin
      in_valid = 1'b1; in_instr = mk(k); in_pc = 32'(k * 4);
      step();
    end
    rst_n = 1'b0; flush = 1'b1; in_instr = mk(13);
    step();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
    total++; if (out_imm !== 32'h0) begin bad++; $display("FAIL rst_mid_imm got=%h exp=0", out_imm); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_mid_pc got=%h exp=0", out_pc); end
    total++; if (out_rd !== 5'd0) begin bad++; $display("FAIL rst_mid_rd got=%0d exp=0", out_rd); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_xlen64();
    test_full();
    test_back_to_back();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
